// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU pipe (req0)
// and the MDU/load unit (req1), plus a pending-write scoreboard for RAW stall checks.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
);

  localparam int NREG = 2**AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  wb_req_t             req [2];
  wb_req_t             sel;
  logic [1:0]          gnt;
  logic                last_grant;
  logic [NREG-1:0]     busy, busy_nxt;

  assign req[0] = '{addr: req0_addr, data: req0_data};
  assign req[1] = '{addr: req1_addr, data: req1_data};

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req_ready = gnt;
  assign sel       = gnt[1] ? req[1] : req[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      wb_we <= 1'b0;
      if (gnt != 2'b00) begin
        last_grant <= gnt[1];
        // Register 0 is hardwired zero: accept the transfer but never write it.
        if (sel.addr != '0) begin
          wb_we   <= 1'b1;
          wb_addr <= sel.addr;
          wb_data <= sel.data;
        end
      end
    end
  end

  // A fresh reservation on the commit edge supersedes the clear.
  always_comb begin
    busy_nxt = busy;
    if (wb_we)
      busy_nxt[wb_addr] = 1'b0;
    if (rsv_valid)
      busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention, scoreboard,
// register-0 handling and reset during activity, with hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready;
  logic [AW-1:0] req0_addr, req1_addr, rsv_addr, rs1_addr, rs2_addr, wb_addr;
  logic [DW-1:0] req0_data, req1_data, wb_data;
  logic          rsv_valid, rs1_busy, rs2_busy, wb_we;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; all driving and sampling happens there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b11;
    req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;
    #2;
    chk("rst_ready", {30'd0, req_ready}, 32'h0);
    chk("rst_we", {31'd0, wb_we}, 32'h0);
    chk("rst_addr", {27'd0, wb_addr}, 32'h0);
    chk("rst_data", wb_data, 32'h0);
    req_valid = 2'b00;
    #10 rst = 1'b0;
    cyc();

    // single request from req0
    req_valid = 2'b01; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1 chk("single_ready", {30'd0, req_ready}, 32'h1);
    cyc();
    req_valid = 2'b00;
    chk("single_we", {31'd0, wb_we}, 32'h1);
    chk("single_addr", {27'd0, wb_addr}, 32'd5);
    chk("single_data", wb_data, 32'hDEADBEEF);
    cyc();
    chk("single_we_off", {31'd0, wb_we}, 32'h0);

    // asynchronous reset pulse mid-cycle clears the registered port at once
    rst = 1'b1;
    #1;
    chk("pulse_we", {31'd0, wb_we}, 32'h0);
    chk("pulse_addr", {27'd0, wb_addr}, 32'h0);
    chk("pulse_data", wb_data, 32'h0);
    chk("pulse_rs1", {31'd0, rs1_busy}, 32'h0);
    chk("pulse_rs2", {31'd0, rs2_busy}, 32'h0);
    #1 rst = 1'b0;
    cyc();

    // contention: req0 first after reset, then alternate
    req_valid = 2'b11;
    req0_addr = 5'd3; req0_data = 32'h33;
    req1_addr = 5'd4; req1_data = 32'h44;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rr_ready%0d", k), {30'd0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      cyc();
      chk($sformatf("rr_we%0d", k), {31'd0, wb_we}, 32'h1);
      chk($sformatf("rr_addr%0d", k), {27'd0, wb_addr}, (k % 2 == 0) ? 32'd3 : 32'd4);
      chk($sformatf("rr_data%0d", k), wb_data, (k % 2 == 0) ? 32'h33 : 32'h44);
    end
    req_valid = 2'b00;
    cyc();
    chk("rr_idle", {31'd0, wb_we}, 32'h0);

    // scoreboard set, then clear on the commit edge
    rsv_valid = 1'b1; rsv_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd6;
    #1 chk("sb_pre", {31'd0, rs1_busy}, 32'h0);
    cyc();
    rsv_valid = 1'b0;
    chk("sb_set", {31'd0, rs1_busy}, 32'h1);
    chk("sb_other", {31'd0, rs2_busy}, 32'h0);
    cyc();
    chk("sb_hold", {31'd0, rs1_busy}, 32'h1);
    req_valid = 2'b01; req0_addr = 5'd7; req0_data = 32'h77;
    cyc();
    req_valid = 2'b00;
    chk("sb_wb_we", {31'd0, wb_we}, 32'h1);
    chk("sb_wb_addr", {27'd0, wb_addr}, 32'd7);
    chk("sb_busy_inflight", {31'd0, rs1_busy}, 32'h1);
    cyc();
    chk("sb_cleared", {31'd0, rs1_busy}, 32'h0);

    // reservation on the same edge as the commit keeps the bit set
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    cyc();
    rsv_valid = 1'b0;
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    chk("sb2_wb_we", {31'd0, wb_we}, 32'h1);
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    cyc();
    rsv_valid = 1'b0;
    chk("sb2_set_wins", {31'd0, rs1_busy}, 32'h1);
    rs2_addr = 5'd7;
    #1 chk("sb2_rs2", {31'd0, rs2_busy}, 32'h1);

    // register 0: accepted but not written, never reserved
    req_valid = 2'b10; req1_addr = 5'd0; req1_data = 32'h1234;
    #1 chk("r0_ready", {30'd0, req_ready}, 32'h2);
    cyc();
    req_valid = 2'b00;
    chk("r0_we", {31'd0, wb_we}, 32'h0);
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    cyc();
    rsv_valid = 1'b0; rs1_addr = 5'd0;
    #1 chk("r0_busy", {31'd0, rs1_busy}, 32'h0);

    // reset while a write is in flight and busy[9] is set
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    cyc();
    rsv_valid = 1'b0;
    req_valid = 2'b01; req0_addr = 5'd2; req0_data = 32'h22;
    cyc();
    req_valid = 2'b00; rs1_addr = 5'd9;
    chk("ra_we_before", {31'd0, wb_we}, 32'h1);
    #1 chk("ra_busy_before", {31'd0, rs1_busy}, 32'h1);
    rst = 1'b1;
    req_valid = 2'b01; req0_addr = 5'd9; req0_data = 32'h99;
    #1;
    chk("ra_we", {31'd0, wb_we}, 32'h0);
    chk("ra_rs1", {31'd0, rs1_busy}, 32'h0);
    chk("ra_rs2", {31'd0, rs2_busy}, 32'h0);
    chk("ra_ready_in_rst", {30'd0, req_ready}, 32'h0);
    rst = 1'b0;
    #1 chk("ra_ready", {30'd0, req_ready}, 32'h1);
    cyc();
    req_valid = 2'b00;
    chk("ra_commit_we", {31'd0, wb_we}, 32'h1);
    chk("ra_commit_addr", {27'd0, wb_addr}, 32'd9);
    chk("ra_commit_data", wb_data, 32'h99);
    cyc();
    chk("ra_idle", {31'd0, wb_we}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
